// File: rtl/cfg_apb_master_if.sv
// Bundle of the command/response handshake and the APB requester pins of cfg_apb_master.
// The master modport is the bridge's view; the slave modport is the command source plus the APB completer.
`timescale 1ns/1ps

`ifndef REG_ADDRWIDTH
`define REG_ADDRWIDTH 32
`endif
`ifndef REG_DATAWIDTH
`define REG_DATAWIDTH 32
`endif

interface cfg_apb_master_if;
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic                      cmd_write;
    logic [`REG_ADDRWIDTH-1:0] cmd_addr;
    logic [`REG_DATAWIDTH-1:0] cmd_wdata;

    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [`REG_DATAWIDTH-1:0] rsp_rdata;
    logic                      rsp_error;

    logic                      PSEL;
    logic                      PENABLE;
    logic                      PWRITE;
    logic [`REG_ADDRWIDTH-1:0] PADDR;
    logic [`REG_DATAWIDTH-1:0] PWDATA;
    logic [`REG_DATAWIDTH-1:0] PRDATA;
    logic                      PREADY;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_error, PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_error, PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/cfg_apb_master.sv
// Single-outstanding command-to-APB bridge: one register access per command, one response per access.
// Optional ACCESS-phase timeout is enabled by defining CFG_APB_TIMEOUT_EN.
`timescale 1ns/1ps

`ifndef REG_ADDRWIDTH
`define REG_ADDRWIDTH 32
`endif
`ifndef REG_DATAWIDTH
`define REG_DATAWIDTH 32
`endif

module cfg_apb_master #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    cfg_apb_master_if.master bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t                    state_reg;
    state_t                    state_next;
    logic                      pwrite_reg;
    logic [`REG_ADDRWIDTH-1:0] paddr_reg;
    logic [`REG_DATAWIDTH-1:0] pwdata_reg;
    logic [`REG_DATAWIDTH-1:0] rsp_rdata_reg;
    logic                      access_done;
    logic                      timeout_hit;

    // PREADY only means anything while the completer is being accessed.
    assign access_done = (state_reg == ST_ACCESS) && bus.PREADY;

`ifdef CFG_APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt_reg;
    logic             rsp_error_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_reg <= '0;
        end else if (state_reg == ST_SETUP) begin
            wait_cnt_reg <= '0;
        end else if ((state_reg == ST_ACCESS) && !bus.PREADY) begin
            wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
        end
    end

    // Abort on the stalled cycle that brings the count to TIMEOUT_CYCLES; a late PREADY still wins.
    assign timeout_hit = (state_reg == ST_ACCESS) && !bus.PREADY &&
                         (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_error_reg <= 1'b0;
        end else if (access_done) begin
            rsp_error_reg <= 1'b0;
        end else if (timeout_hit) begin
            rsp_error_reg <= 1'b1;
        end
    end

    assign bus.rsp_error = rsp_error_reg;
`else
    wire [31:0] unused_timeout_cycles = 32'(TIMEOUT_CYCLES);

    assign timeout_hit   = 1'b0;
    assign bus.rsp_error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (bus.cmd_valid) state_next = ST_SETUP;
            ST_SETUP:  state_next = ST_ACCESS;
            ST_ACCESS: if (access_done || timeout_hit) state_next = ST_RESP;
            ST_RESP:   if (bus.rsp_ready) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready = 1'b0;
        bus.PSEL      = 1'b0;
        bus.PENABLE   = 1'b0;
        bus.rsp_valid = 1'b0;
        case (state_reg)
            ST_IDLE:   bus.cmd_ready = 1'b1;
            ST_SETUP:  bus.PSEL      = 1'b1;
            ST_ACCESS: begin
                bus.PSEL    = 1'b1;
                bus.PENABLE = 1'b1;
            end
            ST_RESP:   bus.rsp_valid = 1'b1;
            default:   bus.cmd_ready = 1'b0;
        endcase
    end

    // Address/data keep the last transaction's values while idle; PSEL qualifies them.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwrite_reg    <= 1'b0;
            paddr_reg     <= '0;
            pwdata_reg    <= '0;
            rsp_rdata_reg <= '0;
        end else begin
            if ((state_reg == ST_IDLE) && bus.cmd_valid) begin
                pwrite_reg <= bus.cmd_write;
                paddr_reg  <= bus.cmd_addr;
                pwdata_reg <= bus.cmd_wdata;
            end
            if (access_done) begin
                rsp_rdata_reg <= pwrite_reg ? '0 : bus.PRDATA;
            end else if (timeout_hit) begin
                rsp_rdata_reg <= '0;
            end
        end
    end

    assign bus.PWRITE    = pwrite_reg;
    assign bus.PADDR     = paddr_reg;
    assign bus.PWDATA    = pwdata_reg;
    assign bus.rsp_rdata = rsp_rdata_reg;

endmodule

// File: tb/tb_cfg_apb_master.sv
// Directed bench for cfg_apb_master: stimulus pushes expected responses, a negedge monitor pops and compares.
// Build with or without CFG_APB_TIMEOUT_EN; the stall/timeout section adapts to the macro.
`timescale 1ns/1ps

`ifndef REG_ADDRWIDTH
`define REG_ADDRWIDTH 32
`endif
`ifndef REG_DATAWIDTH
`define REG_DATAWIDTH 32
`endif

module tb_cfg_apb_master;
    localparam int AW = `REG_ADDRWIDTH;
    localparam int DW = `REG_DATAWIDTH;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cfg_apb_master_if bus();

    cfg_apb_master #(.TIMEOUT_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    int            checks    = 0;
    int            failures  = 0;
    int            rsp_n     = 0;
    int            cyc       = 0;
    int            cfg_wait  = 0;
    logic          cfg_never = 1'b0;
    logic          cfg_noise = 1'b1;
    logic [DW-1:0] cfg_prdata = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [DW-1:0] rd, input logic err);
        exp_t e;
        e.rdata = rd;
        e.err   = err;
        exp_q.push_back(e);
    endtask

    // Completer: PREADY after cfg_wait ACCESS cycles; junk PREADY/PRDATA outside ACCESS.
    initial begin
        int acc_n;
        acc_n      = 0;
        bus.PREADY = 1'b0;
        bus.PRDATA = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.PSEL && bus.PENABLE) begin
                bus.PREADY = !cfg_never && (acc_n == cfg_wait);
                bus.PRDATA = cfg_prdata;
                acc_n++;
            end else begin
                acc_n      = 0;
                bus.PREADY = cfg_noise;
                bus.PRDATA = DW'($urandom);
            end
        end
    end

    // Scoreboard monitor: every response handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && bus.rsp_valid && bus.rsp_ready) begin
            rsp_n++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rsp_unexpected: got rdata=0x%0h err=%0b, expected no response",
                         bus.rsp_rdata, bus.rsp_error);
            end else begin
                mon_e = exp_q.pop_front();
                $display("rsp %0d: rdata=0x%08h err=%0b (expected 0x%08h err=%0b)",
                         rsp_n, bus.rsp_rdata, bus.rsp_error, mon_e.rdata, mon_e.err);
                chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(mon_e.rdata));
                chk("rsp_error", 64'(bus.rsp_error), 64'(mon_e.err));
            end
        end
    end

    task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         output int acc_cyc, output bit ok);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic run_txn(input string tag, input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [DW-1:0] prdata,
                           input int wait_c, input logic never, input int hold,
                           input logic exp_err, input int exp_lat, input int exp_psel,
                           input int exp_pen);
        int            acc_cyc;
        int            psel_n = 0;
        int            pen_n  = 0;
        bit            ok;
        bit            seen     = 1'b0;
        bit            stable   = 1'b1;
        bit            quiet    = 1'b1;
        bit            hold_ok  = 1'b1;
        logic [DW-1:0] exp_rd;
        exp_rd        = (wr || exp_err) ? '0 : prdata;
        cfg_prdata    = prdata;
        cfg_wait      = wait_c;
        cfg_never     = never;
        bus.rsp_ready = 1'b0;
        issue(wr, addr, wdata, acc_cyc, ok);
        chk({tag, "_accept"}, 64'(ok), 64'd1);
        push_exp(exp_rd, exp_err);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.PSEL) begin
                psel_n++;
                if (bus.PADDR !== addr || bus.PWRITE !== wr || bus.PWDATA !== wdata) stable = 1'b0;
            end
            if (bus.PENABLE) pen_n++;
            if (bus.cmd_ready) quiet = 1'b0;
            if (bus.rsp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_rsp_seen"}, 64'(seen), 64'd1);
        chk({tag, "_latency"}, 64'(cyc - acc_cyc), 64'(exp_lat));
        chk({tag, "_psel_cycles"}, 64'(psel_n), 64'(exp_psel));
        chk({tag, "_penable_cycles"}, 64'(pen_n), 64'(exp_pen));
        chk({tag, "_apb_fields"}, 64'(stable), 64'd1);
        chk({tag, "_cmd_ready_low"}, 64'(quiet), 64'd1);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            if (!bus.rsp_valid || bus.cmd_ready || bus.PSEL ||
                bus.rsp_rdata !== exp_rd || bus.rsp_error !== exp_err) hold_ok = 1'b0;
        end
        if (hold > 0) chk({tag, "_rsp_hold"}, 64'(hold_ok), 64'd1);
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        $display("txn %s: wr=%0b addr=0x%0h latency=%0d psel=%0d penable=%0d",
                 tag, wr, addr, cyc - acc_cyc, psel_n, pen_n);
    endtask

    initial begin
        int acc_cyc;
        int n_acc;
        int setup1;
        int setup2;
        int idle_between;
        int stall_len;
        bit ok;
        bit stall_ok;
        bit quiet_ok;

        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        chk("rst_psel_penable", 64'({bus.PSEL, bus.PENABLE, bus.PWRITE}), 64'd0);
        chk("rst_paddr_pwdata", 64'(bus.PADDR) | 64'(bus.PWDATA), 64'd0);
        chk("rst_rsp", 64'({bus.rsp_valid, bus.rsp_error}) | 64'(bus.rsp_rdata), 64'd0);
        @(posedge clk);
        #1;

        // Write with a one-cycle-late completer, then a read held for 5 cycles.
        run_txn("wr4", 1'b1, 32'h4, 32'h1, 32'h5555_AAAA, 1, 1'b0, 0, 1'b0, 4, 3, 2);
        run_txn("rd8", 1'b0, 32'h8, 32'h0, 32'hDEAD_BEEF, 0, 1'b0, 5, 1'b0, 3, 2, 1);
        run_txn("rd1c", 1'b0, 32'h1C, 32'h77, 32'h0123_4567, 2, 1'b0, 1, 1'b0, 5, 4, 3);
        run_txn("wrfffc", 1'b1, 32'hFFFC, 32'hFFFF_FFFF, 32'h1234, 0, 1'b0, 0, 1'b0, 3, 2, 1);

        // Back-to-back writes with cmd_valid and rsp_ready held high.
        cfg_wait      = 0;
        cfg_never     = 1'b0;
        cfg_prdata    = 32'hCAFE_0000;
        bus.rsp_ready = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 32'h10;
        bus.cmd_wdata = 32'hA1;
        n_acc         = 0;
        setup1        = -1;
        setup2        = -1;
        idle_between  = 0;
        for (int i = 0; i < 40 && setup2 < 0; i++) begin
            @(negedge clk);
            if (bus.PSEL && !bus.PENABLE) begin
                if (setup1 < 0) setup1 = cyc;
                else setup2 = cyc;
            end
            if (setup1 >= 0 && setup2 < 0 && bus.cmd_ready) idle_between++;
            if (bus.cmd_ready && bus.cmd_valid) begin
                push_exp('0, 1'b0);
                n_acc++;
            end
            @(posedge clk);
            #1;
            if (n_acc == 1) begin
                bus.cmd_addr  = 32'h14;
                bus.cmd_wdata = 32'hB2;
            end
            if (n_acc == 2) bus.cmd_valid = 1'b0;
        end
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        chk("b2b_accepts", 64'(n_acc), 64'd2);
        chk("b2b_setup_spacing", 64'(setup2 - setup1), 64'd4);
        chk("b2b_idle_cycles", 64'(idle_between), 64'd1);
        chk("b2b_drained", 64'(exp_q.size()), 64'd0);
        $display("txn b2b: accepts=%0d setup_spacing=%0d idle=%0d", n_acc, setup2 - setup1, idle_between);

`ifdef CFG_APB_TIMEOUT_EN
        // Silent completer aborts after 4 ACCESS cycles; PREADY on the 4th cycle completes normally.
        run_txn("tmo", 1'b0, 32'h20, 32'h0, 32'h9999_9999, 0, 1'b1, 2, 1'b1, 6, 5, 4);
        run_txn("tmo_edge", 1'b0, 32'h24, 32'h0, 32'h8765_4321, 3, 1'b0, 0, 1'b0, 6, 5, 4);
        stall_len = 3;
`else
        stall_len = 101;
`endif

        // Stalled read: stays in ACCESS with no response, then reset aborts it.
        cfg_never     = 1'b1;
        bus.rsp_ready = 1'b1;
        issue(1'b0, 32'h30, 32'h0, acc_cyc, ok);
        chk("stall_accept", 64'(ok), 64'd1);
        stall_ok = 1'b1;
        for (int i = 0; i < stall_len; i++) begin
            @(negedge clk);
            if (i >= 1 && !bus.PENABLE) stall_ok = 1'b0;
            if (bus.rsp_valid) stall_ok = 1'b0;
            if (i < stall_len - 1) begin
                @(posedge clk);
                #1;
            end
        end
        chk("stall_no_rsp", 64'(stall_ok), 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_psel_penable", 64'({bus.PSEL, bus.PENABLE}), 64'd0);
        chk("abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("abort_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        chk("abort_paddr", 64'(bus.PADDR), 64'd0);
        cfg_never = 1'b0;
        quiet_ok  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) quiet_ok = 1'b0;
        end
        chk("abort_no_rsp", 64'(quiet_ok), 64'd1);
        $display("txn abort: stalled %0d cycles, reset in ACCESS", stall_len);
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;

        run_txn("post_rst", 1'b0, 32'h8, 32'h0, 32'h0BAD_F00D, 0, 1'b0, 0, 1'b0, 3, 2, 1);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish within 200000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
